rgbw_pwm_gen: RTL and testbench
===============================

Name: rgbw_pwm_gen

Overview:
- Four-channel PWM generator for the red, green, blue and white LED drivers.
- Sits directly downstream of the deserialiser and colour stage, and consumes their per-channel 8-bit duty values.
- Duty updates are double-buffered and applied only at a period boundary, so there are no mid-period glitches.
- Optional phase staggering between channels spreads LED inrush current.

Parameters:
- W, 8: duty and counter width.
- STAGGER, 1: 1 = channel k is phase-offset by k*OFFSET counts; 0 = all channels aligned.
- OFFSET, 64: per-channel phase offset in counts; must be less than PERIOD.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- tick  in  1  count enable from the clock divider; one count per clk cycle with tick=1.
- enable  in  1  1 = run; 0 = outputs forced low, counter held at 0.
- load  in  1  one-cycle strobe; captures duty_* into the shadow registers.
- duty_r  in  W  red duty.
- duty_g  in  W  green duty.
- duty_b  in  W  blue duty.
- duty_w  in  W  white duty.
- pwm_r  out  1  red PWM, registered.
- pwm_g  out  1  green PWM, registered.
- pwm_b  out  1  blue PWM, registered.
- pwm_w  out  1  white PWM, registered.
- period_start  out  1  one-cycle pulse when the counter wraps to 0.
- pending  out  1  shadow holds values not yet applied.

Behaviour:
- Reset (reset=0 at a clk edge):
  - cnt, shadow regs, active regs, pending, period_start and all pwm_* go to 0.
  - Reset overrides every other input, including mid-period.
- Counter:
  - PERIOD = 2^W - 1 = 255 counts; cnt runs 0..254.
  - On clk with enable=1 and tick=1: cnt <= (cnt==254) ? 0 : cnt+1.
  - With tick=0, cnt holds.
- Wrap event: enable=1, tick=1 and cnt==254.
  - period_start=1 in the following cycle only.
  - If pending=1, active_* <= shadow_* and pending <= 0.
- Load:
  - load=1 captures all four duty_* into shadow and sets pending=1.
  - Load while pending=1: overwrite, last load wins.
  - Load coincident with wrap: the wrap transfers the old shadow to active; the new values go into shadow and pending stays 1. They apply at the next wrap.
- Phase per channel k (r=0, g=1, b=2, w=3):
  - ph_k = cnt + k*OFFSET when STAGGER=1, else cnt.
  - If ph_k >= PERIOD, subtract PERIOD. Compute in W+2 bits; no overflow is permitted.
- Output:
  - pwm_k <= enable & (ph_k < active_k), evaluated on current registered cnt and active values.
  - This gives one clk of latency from a cnt or active change to the pin.
  - duty=0: output always low. duty=255: output always high (100%). duty=d: exactly d high counts per 255-count period.
- Disable (enable=0):
  - cnt <= 0, all pwm_* <= 0 next cycle, period_start=0.
  - A load while disabled writes shadow and active directly; pending stays 0.
  - Re-enable starts from cnt=0 with the current active values; no wrap pulse is generated at re-enable.
- tick high every cycle is legal; period_start must never be wider than 1 cycle.

Decomposition:
- Shared package rgbw_pkg holds:
  - constants PWM_W=8, PWM_PERIOD=255, PWM_NCH=4, PWM_OFFSET=64;
  - channel index constants CH_R=0, CH_G=1, CH_B=2, CH_W=3.
- One sub-module, rgbw_pwm_channel, instantiated four times. Its parameter is the phase offset; its inputs are clk, reset, enable, cnt and active duty.
  - Contains the modulo phase add, the compare and the registered output.
- The top level holds the counter, shadow/active registers, pending flag and period_start.

Test Plan:
- Duty update and PWM width: reset, enable=1, tick=1 every cycle, STAGGER=0, load r=0, g=1, b=128, w=255.
  - After the first period_start: per 255-cycle period, pwm_r is high 0 cycles, pwm_g 1, pwm_b 128, pwm_w 255.
- Double-buffering: mid-period (cnt=100), load r=10.
  - pending=1; the pwm_r pattern is unchanged until the wrap.
  - The next period has 10 high cycles and pending returns to 0.
- Load coincident with wrap: shadow r=50 pending; load r=20 in the same cycle as the wrap.
  - The next period has 50 high cycles and pending=1.
  - The following period has 20 high cycles.
- Stagger: STAGGER=1, all duties=64.
  - Each pwm is high 64 cycles per period.
  - Rising edges of g, b and w lead r by 64, 128 and 192 counts respectively (ph_k wraps modulo 255).
- tick gating: tick asserted every 4th cycle, duty_r=3.
  - The period is 1020 clk cycles with pwm_r high for 12 clk cycles.
  - period_start is exactly 1 cycle wide.
- Disable and reset mid-operation:
  - Deassert enable at cnt=77: all pwm are 0 the next cycle and cnt=0.
  - Load while disabled, then re-enable: new duty is active immediately.
  - Assert reset=0 mid-period: all outputs and pending are 0 at the next edge.

Source files
------------

// File: rtl/rgbw_pkg.sv
// Shared constants for the RGBW PWM generator: default widths, channel indices
// and the per-channel phase offset helper.
package rgbw_pkg;
  localparam int PWM_W      = 8;
  localparam int PWM_PERIOD = 255;
  localparam int PWM_NCH    = 4;
  localparam int PWM_OFFSET = 64;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;
  localparam int CH_W = 3;

  // Reduced modulo the period so the channel needs only one conditional subtract.
  function automatic int phase_off(input int k, input int stagger,
                                   input int offset, input int period);
    return (stagger != 0) ? (k * offset) % period : 0;
  endfunction
endpackage

// File: rtl/rgbw_pwm_channel.sv
// One PWM lane: modulo phase add of a fixed offset, duty compare, registered pin.
module rgbw_pwm_channel
  import rgbw_pkg::*;
#(
  parameter int W      = PWM_W,
  parameter int PH_OFF = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] duty,
  output logic         pwm
);
  localparam int PERIOD = (1 << W) - 1;

  logic [W+1:0] ph_sum;
  logic [W+1:0] ph;

  always_comb begin
    ph_sum = {2'b00, cnt} + (W+2)'(PH_OFF);
    ph     = (ph_sum >= (W+2)'(PERIOD)) ? ph_sum - (W+2)'(PERIOD) : ph_sum;
  end

  always_ff @(posedge clk) begin
    if (!reset) pwm <= 1'b0;
    else        pwm <= enable & (ph < {2'b00, duty});
  end
endmodule

// File: rtl/rgbw_pwm_gen.sv
// Four-channel RGBW PWM generator with double-buffered duties applied at the
// period wrap and optional per-channel phase staggering.
module rgbw_pwm_gen
  import rgbw_pkg::*;
#(
  parameter int W       = PWM_W,
  parameter int STAGGER = 1,
  parameter int OFFSET  = PWM_OFFSET
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] duty_r,
  input  logic [W-1:0] duty_g,
  input  logic [W-1:0] duty_b,
  input  logic [W-1:0] duty_w,
  output logic         pwm_r,
  output logic         pwm_g,
  output logic         pwm_b,
  output logic         pwm_w,
  output logic         period_start,
  output logic         pending
);
  localparam int PERIOD = (1 << W) - 1;

  logic [W-1:0]                  cnt;
  logic [PWM_NCH-1:0][W-1:0]     duty;
  logic [PWM_NCH-1:0][W-1:0]     shadow;
  logic [PWM_NCH-1:0][W-1:0]     active;
  logic [PWM_NCH-1:0]            pwm;
  logic                          wrap;

  assign duty[CH_R] = duty_r;
  assign duty[CH_G] = duty_g;
  assign duty[CH_B] = duty_b;
  assign duty[CH_W] = duty_w;

  assign wrap = enable & tick & (cnt == W'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt          <= '0;
      shadow       <= '0;
      active       <= '0;
      pending      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (!enable) begin
        cnt <= '0;
        // Nothing is running, so a load goes straight to the active set.
        if (load) begin
          shadow  <= duty;
          active  <= duty;
          pending <= 1'b0;
        end
      end else begin
        if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
        if (wrap && pending) active <= shadow;
        // A load on the wrap cycle lands after the old shadow has moved over.
        if (load) begin
          shadow  <= duty;
          pending <= 1'b1;
        end else if (wrap) begin
          pending <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < PWM_NCH; k++) begin : g_ch
    rgbw_pwm_channel #(
      .W      (W),
      .PH_OFF (phase_off(k, STAGGER, OFFSET, PERIOD))
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .cnt    (cnt),
      .duty   (active[k]),
      .pwm    (pwm[k])
    );
  end

  assign pwm_r = pwm[CH_R];
  assign pwm_g = pwm[CH_G];
  assign pwm_b = pwm[CH_B];
  assign pwm_w = pwm[CH_W];
endmodule

// File: tb/tb_rgbw_pwm_gen.sv
// Scoreboard bench: aligned and staggered instances share stimulus; a monitor
// measures each period between period_start pulses and checks queued expectations.
module tb_rgbw_pwm_gen;
  logic       clk = 1'b0;
  logic       reset = 1'b0, tick = 1'b0, enable = 1'b0, load = 1'b0;
  logic [7:0] duty_r = '0, duty_g = '0, duty_b = '0, duty_w = '0;
  logic [3:0] p0, p1;
  logic       ps0, ps1, pend0, pend1;

  bit tick_on = 1'b0, tick_div4 = 1'b0;
  int tph = 0;

  always #5 clk = ~clk;

  rgbw_pwm_gen #(.W(8), .STAGGER(0), .OFFSET(64)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable), .load(load),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .duty_w(duty_w),
    .pwm_r(p0[0]), .pwm_g(p0[1]), .pwm_b(p0[2]), .pwm_w(p0[3]),
    .period_start(ps0), .pending(pend0));

  rgbw_pwm_gen #(.W(8), .STAGGER(1), .OFFSET(64)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable), .load(load),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .duty_w(duty_w),
    .pwm_r(p1[0]), .pwm_g(p1[1]), .pwm_b(p1[2]), .pwm_w(p1[3]),
    .period_start(ps1), .pending(pend1));

  typedef struct packed {
    logic [3:0][15:0] hi;    // high samples per period, both instances
    logic [3:0][15:0] rise;  // staggered instance first-rise index, FFFF = don't care
    logic [15:0]      len;   // samples per period
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int r, input int g, input int b, input int w, input int len);
    exp_t x;
    x.hi   = {16'(w), 16'(b), 16'(g), 16'(r)};
    x.rise = {4{16'hFFFF}};
    x.len  = 16'(len);
    return x;
  endfunction

  // tick source: every cycle or every 4th cycle
  initial forever begin
    @(posedge clk); #1;
    tick = tick_div4 ? (tph == 3) : tick_on;
    tph  = (tph + 1) % 4;
  end

  // Monitor
  int acc0[4], acc1[4], rise1[4];
  int len = 0, wide = 0;
  bit open = 0, prev_run = 0, prev_ps = 0;
  logic [3:0] pp1 = '0;

  task automatic clear_win();
    for (int k = 0; k < 4; k++) begin acc0[k] = 0; acc1[k] = 0; rise1[k] = -1; end
    len = 0; wide = 0;
  endtask

  always @(negedge clk) begin
    if (!(reset && enable)) open = 0;
    else if (!prev_run) begin open = 1; clear_win(); end
    else if (open) begin
      len++;
      for (int k = 0; k < 4; k++) begin
        acc0[k] += int'(p0[k]);
        acc1[k] += int'(p1[k]);
        if (p1[k] && !pp1[k] && rise1[k] < 0) rise1[k] = len;
      end
      if (ps0 && prev_ps) wide++;
      if (ps0) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          for (int k = 0; k < 4; k++) begin
            chk($sformatf("hi_aligned_ch%0d", k), acc0[k], int'(e.hi[k]));
            chk($sformatf("hi_stagger_ch%0d", k), acc1[k], int'(e.hi[k]));
            if (e.rise[k] != 16'hFFFF)
              chk($sformatf("rise_stagger_ch%0d", k), rise1[k], int'(e.rise[k]));
          end
          chk("period_len", len, int'(e.len));
          chk("period_start_width", wide, 0);
          chk("period_start_sync", int'(ps1), int'(ps0));
        end
        clear_win();
      end
    end
    pp1      = p1;
    prev_ps  = ps0;
    prev_run = reset && enable;
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns one posedge after a period_start sample, i.e. with cnt == 1.
  task automatic wait_ps();
    int n = 0;
    do begin @(negedge clk); n++; end while (!ps0 && n < 3000);
    if (!ps0) chk("period_start_timeout", 0, 1);
    adv(1);
  endtask

  task automatic do_load();
    load = 1'b1; adv(1); load = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    adv(3);
    chk("reset_pwm_aligned", int'(p0), 0);
    chk("reset_pwm_stagger", int'(p1), 0);
    chk("reset_pending", int'(pend0), 0);
    chk("reset_period_start", int'(ps0 | ps1), 0);

    // Duty update and widths
    reset = 1'b1; enable = 1'b1; tick_on = 1'b1;
    duty_r = 8'd0; duty_g = 8'd1; duty_b = 8'd128; duty_w = 8'd255;
    do_load();
    chk("pending_after_load", int'(pend0), 1);
    wait_ps();
    chk("pending_after_wrap", int'(pend0), 0);
    q.push_back(mk(0, 1, 128, 255, 255));
    wait_ps();

    // Double buffering: load r=10 at cnt=100
    q.push_back(mk(0, 1, 128, 255, 255));
    adv(99);
    duty_r = 8'd10; do_load();
    chk("pending_mid_period", int'(pend1), 1);
    wait_ps();
    chk("pending_cleared", int'(pend0), 0);
    q.push_back(mk(10, 1, 128, 255, 255));

    // Load r=50 mid-period, then r=20 on the wrap cycle
    adv(49);
    duty_r = 8'd50; do_load();
    adv(203);
    duty_r = 8'd20; do_load();
    chk("pending_load_on_wrap", int'(pend0), 1);
    q.push_back(mk(50, 1, 128, 255, 255));
    wait_ps();
    chk("pending_held_next_period", int'(pend0), 1);
    wait_ps();
    chk("pending_after_second_wrap", int'(pend0), 0);
    q.push_back(mk(20, 1, 128, 255, 255));

    // Stagger: all 64
    duty_r = 8'd64; duty_g = 8'd64; duty_b = 8'd64; duty_w = 8'd64;
    do_load();
    wait_ps();
    x = mk(64, 64, 64, 64, 255);
    x.rise = {16'd64, 16'd128, 16'd192, 16'd1};
    q.push_back(x);
    wait_ps();

    // tick every 4th cycle, r=3
    duty_r = 8'd3; do_load();
    tick_div4 = 1'b1;
    wait_ps();
    q.push_back(mk(12, 256, 256, 256, 1020));
    wait_ps();
    tick_div4 = 1'b0;
    wait_ps();

    // Disable at cnt=77, load while disabled, re-enable
    adv(76);
    enable = 1'b0;
    adv(1);
    chk("disable_pwm_aligned", int'(p0), 0);
    chk("disable_pwm_stagger", int'(p1), 0);
    chk("disable_period_start", int'(ps0), 0);
    duty_r = 8'd200; do_load();
    chk("pending_disabled_load", int'(pend0), 0);
    enable = 1'b1;
    q.push_back(mk(200, 64, 64, 64, 255));
    adv(1);
    chk("no_period_start_on_enable", int'(ps0), 0);
    wait_ps();

    // Reset mid-period with a pending load
    adv(50);
    duty_r = 8'd9; do_load();
    chk("pending_before_reset", int'(pend0), 1);
    reset = 1'b0;
    adv(1);
    chk("midreset_pwm_aligned", int'(p0), 0);
    chk("midreset_pwm_stagger", int'(p1), 0);
    chk("midreset_pending", int'(pend0 | pend1), 0);
    chk("midreset_period_start", int'(ps0 | ps1), 0);
    reset = 1'b1;
    adv(2);
    chk("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
